// File: rtl/pkt_writer_if.sv
// Byte-stream ingress, mem write bus and proc start handshake used by pkt_writer.
// master = pkt_writer side, slave = port/mem/proc side.
interface pkt_writer_if;
    logic        in_valid_i;
    logic [7:0]  in_data_i;
    logic        in_last_i;
    logic        in_ready_o;
    logic        mem_ce_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_width_o;
    logic [31:0] mem_data_o;
    logic        proc_ready_i;
    logic        proc_start_o;
    logic [31:0] pkt_addr_o;

    modport master (
        input  in_valid_i, in_data_i, in_last_i, proc_ready_i,
        output in_ready_o, mem_ce_o, mem_we_o, mem_addr_o, mem_width_o, mem_data_o,
        output proc_start_o, pkt_addr_o
    );

    modport slave (
        output in_valid_i, in_data_i, in_last_i, proc_ready_i,
        input  in_ready_o, mem_ce_o, mem_we_o, mem_addr_o, mem_width_o, mem_data_o,
        input  proc_start_o, pkt_addr_o
    );
endinterface

// File: rtl/pkt_writer.sv
// Packs an ingress byte stream into 32-bit words, writes a length header, then starts proc.
// Define PKT_WRITER_TRUNC_FLAG_EN to report truncation in header bit 31.
module pkt_writer #(
    parameter logic [31:0] BASE_ADDR = 32'd0,
    parameter int          MAX_LEN   = 1514
) (
    input  logic         clk,
    input  logic         rst,
    pkt_writer_if.master io_bus
);
    localparam int          LEN_W   = $clog2(MAX_LEN + 1);
    localparam logic [31:0] LEN_MAX = MAX_LEN;

    typedef enum logic [2:0] {RECV, TAIL, HDR, START, BUSY} state_t;

    state_t           r_state;
    logic [31:0]      r_pack;
    logic [LEN_W-1:0] r_len;
    logic             r_trunc;
    logic [1:0]       r_tail_left;
    logic             r_busy_first;
    logic             r_ce;
    logic [31:0]      r_addr;
    logic [3:0]       r_width;
    logic [31:0]      r_data;
    logic             r_start;

    logic        w_ready;
    logic        w_accept;
    logic        w_store;
    logic        w_word_done;
    logic [31:0] w_len_cur;
    logic [31:0] w_len_next;
    logic [31:0] w_pack_next;
    logic [1:0]  w_rem;
    logic [31:0] w_hdr;

    function automatic logic [7:0] pick_byte(input logic [31:0] word, input logic [1:0] pos);
        case (pos)
            2'd0:    pick_byte = word[7:0];
            2'd1:    pick_byte = word[15:8];
            2'd2:    pick_byte = word[23:16];
            default: pick_byte = word[31:24];
        endcase
    endfunction

    assign w_ready     = (r_state == RECV) && !rst;
    assign w_accept    = io_bus.in_valid_i && w_ready;
    assign w_len_cur   = 32'(r_len);
    assign w_store     = w_len_cur < LEN_MAX;
    assign w_len_next  = w_store ? w_len_cur + 32'd1 : w_len_cur;
    assign w_pack_next = w_store ? {r_pack[23:0], io_bus.in_data_i} : r_pack;
    assign w_word_done = w_store && (w_len_cur[1:0] == 2'd3);
    assign w_rem       = w_len_next[1:0];

`ifdef PKT_WRITER_TRUNC_FLAG_EN
    assign w_hdr = {r_trunc, w_len_cur[30:0]};
`else
    assign w_hdr = w_len_cur;
`endif

    // Each write is launched on the edge that decides it, so the first tail byte
    // leaves with the last accepted byte and TAIL only covers the remaining ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= RECV;
            r_pack       <= '0;
            r_len        <= '0;
            r_trunc      <= 1'b0;
            r_tail_left  <= '0;
            r_busy_first <= 1'b0;
            r_ce         <= 1'b0;
            r_addr       <= '0;
            r_width      <= '0;
            r_data       <= '0;
            r_start      <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults make ce/start single-cycle pulses; later assignments win.
            r_ce    <= 1'b0;
            r_start <= 1'b0;
            case (r_state)
                RECV: if (w_accept) begin
                    r_pack <= w_pack_next;
                    r_len  <= w_len_next[LEN_W-1:0];
                    if (!w_store) r_trunc <= 1'b1;
                    if (w_word_done) begin
                        r_ce    <= 1'b1;
                        r_width <= 4'd4;
                        r_addr  <= BASE_ADDR + 32'd1 + w_len_cur;
                        r_data  <= w_pack_next;
                    end
                    if (io_bus.in_last_i) begin
                        if (w_rem == 2'd0) begin
                            r_state <= HDR;
                        end else begin
                            r_ce        <= 1'b1;
                            r_width     <= 4'd1;
                            r_addr      <= BASE_ADDR + 32'd4 + w_len_next - {30'd0, w_rem};
                            r_data      <= {24'd0, pick_byte(w_pack_next, w_rem - 2'd1)};
                            r_tail_left <= w_rem - 2'd1;
                            r_state     <= (w_rem == 2'd1) ? HDR : TAIL;
                        end
                    end
                end
                TAIL: begin
                    r_ce        <= 1'b1;
                    r_width     <= 4'd1;
                    r_addr      <= r_addr + 32'd1;
                    r_data      <= {24'd0, pick_byte(r_pack, r_tail_left - 2'd1)};
                    r_tail_left <= r_tail_left - 2'd1;
                    if (r_tail_left == 2'd1) r_state <= HDR;
                end
                HDR: begin
                    r_ce    <= 1'b1;
                    r_width <= 4'd4;
                    r_addr  <= BASE_ADDR;
                    r_data  <= w_hdr;
                    r_state <= START;
                end
                START: if (io_bus.proc_ready_i) begin
                    r_start      <= 1'b1;
                    r_busy_first <= 1'b1;
                    r_state      <= BUSY;
                end
                BUSY: begin
                    // proc still shows ready in the cycle it samples the start pulse
                    if (r_busy_first) begin
                        r_busy_first <= 1'b0;
                    end else if (io_bus.proc_ready_i) begin
                        r_len   <= '0;
                        r_trunc <= 1'b0;
                        r_state <= RECV;
                    end
                end
                default: r_state <= RECV;
            endcase
        end
    end

    assign io_bus.in_ready_o   = w_ready;
    assign io_bus.mem_ce_o     = r_ce;
    assign io_bus.mem_we_o     = r_ce;
    assign io_bus.mem_addr_o   = r_addr;
    assign io_bus.mem_width_o  = r_width;
    assign io_bus.mem_data_o   = r_data;
    assign io_bus.proc_start_o = r_start;
    assign io_bus.pkt_addr_o   = BASE_ADDR + 32'd4;
endmodule

// File: tb/tb_pkt_writer.sv
// Self-checking bench for pkt_writer: randomized packets scored against a packet-level model
// of the expected write list and start timing.
module tb_pkt_writer;
    localparam logic [31:0] BASE = 32'h0000_0040;
    localparam int          MAXL = 16;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  width;
        logic [31:0] data;
        logic [31:0] cyc;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pkt_writer_if bus ();

    pkt_writer #(.BASE_ADDR(BASE), .MAX_LEN(MAXL)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    wr_t        got_q[$];
    wr_t        exp_q[$];
    int         start_q[$];
    int         acc_q[$];
    logic [7:0] pkt_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records every write and start pulse with the cycle it is visible in.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            checks++;
            if (bus.mem_we_o !== bus.mem_ce_o) begin
                errors++;
                $display("FAIL we_eq_ce: we=%b ce=%b at cycle %0d", bus.mem_we_o, bus.mem_ce_o, cyc);
            end
            if (bus.mem_ce_o === 1'b1)
                got_q.push_back({bus.mem_addr_o, bus.mem_width_o, bus.mem_data_o, 32'(cyc)});
            if (bus.proc_start_o === 1'b1) start_q.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    // Reference model: expected writes (with cycles) from the bytes and their accept cycles.
    task automatic build_exp(output int hdr_c);
        int n;
        int st;
        int r;
        int t;
        logic [31:0] h;
        n  = pkt_q.size();
        st = (n > MAXL) ? MAXL : n;
        r  = st % 4;
        t  = acc_q[n-1];
        exp_q.delete();
        for (int w = 0; w < st / 4; w++)
            exp_q.push_back({BASE + 32'd4 + 32'(4 * w), 4'd4,
                             {pkt_q[4*w], pkt_q[4*w+1], pkt_q[4*w+2], pkt_q[4*w+3]},
                             32'(acc_q[4*w+3] + 1)});
        for (int j = 0; j < r; j++)
            exp_q.push_back({BASE + 32'd4 + 32'(st - r + j), 4'd1, {24'd0, pkt_q[st-r+j]}, 32'(t + 1 + j)});
        hdr_c = t + ((r == 0) ? 2 : r + 1);
        h = 32'(st);
`ifdef PKT_WRITER_TRUNC_FLAG_EN
        if (n > MAXL) h[31] = 1'b1;
`endif
        exp_q.push_back({BASE, 4'd4, h, 32'(hdr_c)});
    endtask

    task automatic send_pkt(input int gap, input bit with_last);
        int g;
        int waited;
        acc_q.delete();
        for (int i = 0; i < pkt_q.size(); i++) begin
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            bus.in_valid_i = 1'b0;
            repeat (g) @(negedge clk);
            bus.in_valid_i = 1'b1;
            bus.in_data_i  = pkt_q[i];
            bus.in_last_i  = with_last && (i == pkt_q.size() - 1);
            waited = 0;
            while (bus.in_ready_o !== 1'b1 && waited < 40) begin
                @(negedge clk);
                waited++;
            end
            if (bus.in_ready_o !== 1'b1) begin
                checks++;
                errors++;
                $display("FAIL in_ready_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready_o, waited);
            end
            acc_q.push_back(cyc);
            @(negedge clk);
        end
        bus.in_valid_i = 1'b0;
        bus.in_last_i  = 1'b0;
    endtask

    task automatic wait_done(output int start_c, output int rdy_c);
        int n;
        n = 0;
        while (start_q.size() == 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (start_q.size() == 0) begin
            errors++;
            start_c = -1;
            $display("FAIL start_timeout: no proc_start within %0d cycles, required one", n);
        end else begin
            start_c = start_q[0];
        end
        n = 0;
        while (bus.in_ready_o !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        rdy_c = cyc;
        checks++;
        if (bus.in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL recv_timeout: in_ready=%b, required return to 1", bus.in_ready_o);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic fill_pkt(input int len);
        pkt_q.delete();
        for (int i = 0; i < len; i++) pkt_q.push_back(8'($urandom));
    endtask

    task automatic test_reset();
        bus.in_valid_i = 1'b0; bus.in_data_i = 8'h00; bus.in_last_i = 1'b0; bus.proc_ready_i = 1'b1;
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.in_ready_o, bus.mem_ce_o, bus.mem_we_o, bus.proc_start_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: ready/ce/we/start=%b, required 0000",
                     {bus.in_ready_o, bus.mem_ce_o, bus.mem_we_o, bus.proc_start_o});
        end
        checks++;
        if ({bus.mem_addr_o, bus.mem_width_o, bus.mem_data_o} !== 68'd0) begin
            errors++;
            $display("FAIL reset_bus: addr=%h width=%h data=%h, required 0", bus.mem_addr_o, bus.mem_width_o, bus.mem_data_o);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: in_ready=%b, required 1", bus.in_ready_o);
        end
        checks++;
        if (bus.pkt_addr_o !== BASE + 32'd4) begin
            errors++;
            $display("FAIL pkt_addr: got %h, required %h", bus.pkt_addr_o, BASE + 32'd4);
        end
    endtask

    task automatic test_word_aligned();
        int hdr_c, start_c, rdy_c, t;
        pkt_q.delete();
        for (int i = 0; i < 8; i++) pkt_q.push_back(8'(i));
        got_q.delete(); start_q.delete();
        send_pkt(0, 1'b1);
        t = acc_q[7];
        build_exp(hdr_c);
        wait_done(start_c, rdy_c);
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL aligned_count: got %0d writes, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL aligned_wr%0d: got %h/%0d/%h@%0d, required %h/%0d/%h@%0d", i,
                         got_q[i].addr, got_q[i].width, got_q[i].data, got_q[i].cyc,
                         exp_q[i].addr, exp_q[i].width, exp_q[i].data, exp_q[i].cyc);
            end
        end
        if (got_q.size() == 3) begin
            checks++;
            if (got_q[1].data !== 32'h04050607 || got_q[2].data !== 32'd8) begin
                errors++;
                $display("FAIL aligned_words: word1=%h hdr=%h, required 04050607 / 00000008", got_q[1].data, got_q[2].data);
            end
        end
        checks++;
        if (start_c !== t + 3) begin
            errors++;
            $display("FAIL aligned_start: start at %0d, required %0d", start_c, t + 3);
        end
        checks++;
        if (rdy_c !== start_c + 2) begin
            errors++;
            $display("FAIL aligned_busy: in_ready back at %0d, required %0d", rdy_c, start_c + 2);
        end
    endtask

    task automatic test_partial_tail();
        int hdr_c, start_c, rdy_c, t;
        pkt_q.delete();
        for (int i = 0; i < 6; i++) pkt_q.push_back(8'(i));
        got_q.delete(); start_q.delete();
        send_pkt(0, 1'b1);
        t = acc_q[5];
        build_exp(hdr_c);
        wait_done(start_c, rdy_c);
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL tail_count: got %0d writes, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL tail_wr%0d: got %h/%0d/%h@%0d, required %h/%0d/%h@%0d", i,
                         got_q[i].addr, got_q[i].width, got_q[i].data, got_q[i].cyc,
                         exp_q[i].addr, exp_q[i].width, exp_q[i].data, exp_q[i].cyc);
            end
        end
        checks++;
        if (start_c !== t + 4) begin
            errors++;
            $display("FAIL tail_start: start at %0d, required %0d", start_c, t + 4);
        end
    endtask

    task automatic test_backpressure();
        int hdr_c, c;
        fill_pkt(4);
        got_q.delete(); start_q.delete();
        bus.proc_ready_i = 1'b0;
        send_pkt(0, 1'b1);
        build_exp(hdr_c);
        repeat (hdr_c + 4 - cyc) @(negedge clk);
        checks++;
        if (start_q.size() !== 0 || bus.in_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold: starts=%0d in_ready=%b, required 0 / 0", start_q.size(), bus.in_ready_o);
        end
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL bp_count: got %0d writes, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bp_wr%0d: got %h/%0d/%h@%0d, required %h/%0d/%h@%0d", i,
                         got_q[i].addr, got_q[i].width, got_q[i].data, got_q[i].cyc,
                         exp_q[i].addr, exp_q[i].width, exp_q[i].data, exp_q[i].cyc);
            end
        end
        bus.proc_ready_i = 1'b1;
        c = cyc;
        @(negedge clk);
        checks++;
        if (bus.proc_start_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_start: proc_start=%b one cycle after ready at %0d, required 1", bus.proc_start_o, c);
        end
        bus.proc_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.in_ready_o !== 1'b0 || bus.proc_start_o !== 1'b0) begin
                errors++;
                $display("FAIL bp_busy%0d: in_ready=%b start=%b, required 0 / 0", i, bus.in_ready_o, bus.proc_start_o);
            end
        end
        bus.proc_ready_i = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_return: in_ready=%b, required 1", bus.in_ready_o);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_oversize();
        int hdr_c, start_c, rdy_c, nw;
        logic [31:0] exp_h;
        fill_pkt(20);
        got_q.delete(); start_q.delete();
        send_pkt(0, 1'b1);
        build_exp(hdr_c);
        wait_done(start_c, rdy_c);
        checks++;
        if (acc_q.size() !== 20) begin
            errors++;
            $display("FAIL over_accept: accepted %0d bytes, required 20", acc_q.size());
        end
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL over_count: got %0d writes, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL over_wr%0d: got %h/%0d/%h@%0d, required %h/%0d/%h@%0d", i,
                         got_q[i].addr, got_q[i].width, got_q[i].data, got_q[i].cyc,
                         exp_q[i].addr, exp_q[i].width, exp_q[i].data, exp_q[i].cyc);
            end
        end
`ifdef PKT_WRITER_TRUNC_FLAG_EN
        exp_h = 32'h8000_0010;
`else
        exp_h = 32'h0000_0010;
`endif
        nw = 0;
        foreach (got_q[i]) if (got_q[i].addr != BASE) nw++;
        checks++;
        if (nw !== 4 || got_q.size() == 0 || got_q[got_q.size()-1].data !== exp_h) begin
            errors++;
            $display("FAIL over_hdr: %0d data writes, header %h, required 4 / %h", nw,
                     (got_q.size() == 0) ? 32'hx : got_q[got_q.size()-1].data, exp_h);
        end
    endtask

    task automatic test_reset_mid_packet();
        int hdr_c, start_c, rdy_c;
        fill_pkt(3);
        got_q.delete(); start_q.delete();
        send_pkt(0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL midrst_ready: in_ready=%b during reset, required 0", bus.in_ready_o);
        end
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (got_q.size() !== 0 || start_q.size() !== 0) begin
            errors++;
            $display("FAIL midrst_quiet: %0d writes %0d starts, required 0 / 0", got_q.size(), start_q.size());
        end
        pkt_q.delete();
        pkt_q.push_back(8'hAA); pkt_q.push_back(8'hBB); pkt_q.push_back(8'hCC); pkt_q.push_back(8'hDD);
        send_pkt(0, 1'b1);
        build_exp(hdr_c);
        wait_done(start_c, rdy_c);
        checks++;
        if (got_q.size() !== 2 || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin
            errors++;
            $display("FAIL midrst_pkt: %0d writes, first %h/%h, required 2 writes %h/%h then hdr %h",
                     got_q.size(), (got_q.size() > 0) ? got_q[0].addr : 32'hx, (got_q.size() > 0) ? got_q[0].data : 32'hx,
                     exp_q[0].addr, exp_q[0].data, exp_q[1].data);
        end
        checks++;
        if (exp_q[0].data !== 32'hAABBCCDD || exp_q[1].data !== 32'd4 || start_c !== hdr_c + 1) begin
            errors++;
            $display("FAIL midrst_ref: start at %0d, required %0d", start_c, hdr_c + 1);
        end
    endtask

    task automatic test_gapped();
        int hdr_c, start_c, rdy_c;
        fill_pkt(5);
        got_q.delete(); start_q.delete();
        send_pkt(2, 1'b1);
        build_exp(hdr_c);
        wait_done(start_c, rdy_c);
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL gap_count: got %0d writes, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL gap_wr%0d: got %h/%0d/%h@%0d, required %h/%0d/%h@%0d", i,
                         got_q[i].addr, got_q[i].width, got_q[i].data, got_q[i].cyc,
                         exp_q[i].addr, exp_q[i].width, exp_q[i].data, exp_q[i].cyc);
            end
        end
        checks++;
        if (got_q.size() > 1 && got_q[1].addr !== BASE + 32'd8) begin
            errors++;
            $display("FAIL gap_tail_addr: got %h, required %h", got_q[1].addr, BASE + 32'd8);
        end
    endtask

    task automatic test_random();
        int hdr_c, start_c, rdy_c;
        for (int p = 0; p < 12; p++) begin
            fill_pkt(int'($urandom_range(1, 22)));
            got_q.delete(); start_q.delete();
            send_pkt(-1, 1'b1);
            build_exp(hdr_c);
            wait_done(start_c, rdy_c);
            checks++;
            if (got_q.size() !== exp_q.size()) begin
                errors++;
                $display("FAIL rnd%0d_count: len %0d got %0d writes, required %0d", p, pkt_q.size(), got_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rnd%0d_wr%0d: got %h/%0d/%h@%0d, required %h/%0d/%h@%0d", p, i,
                             got_q[i].addr, got_q[i].width, got_q[i].data, got_q[i].cyc,
                             exp_q[i].addr, exp_q[i].width, exp_q[i].data, exp_q[i].cyc);
                end
            end
            checks++;
            if (start_c !== hdr_c + 1 || rdy_c !== start_c + 2) begin
                errors++;
                $display("FAIL rnd%0d_timing: start %0d ready %0d, required %0d / %0d", p, start_c, rdy_c, hdr_c + 1, hdr_c + 3);
            end
        end
    endtask

    initial begin
        test_reset();
        test_word_aligned();
        test_partial_tail();
        test_backpressure();
        test_oversize();
        test_reset_mid_packet();
        test_gapped();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
